ram128_axil_ctrl: RTL and testbench
===================================

// Module: ram128_axil_ctrl
// PURPOSE
// AXI4-Lite slave that owns the single port of one RAM128 instance (128 x WSIZE*8).
// Turns AXI-Lite read/write transactions into RAM EN0/WE0/A0/Di0 cycles and returns Do0 as rdata.
// The PDK macro only writes full words, so when PDK_FULLWORD=1 a partial-strobe write becomes a read-modify-write.
// Sits between the FSIC AXI-Lite interconnect and the RAM128 wrapper.
// PARAMETERS
// WSIZE         4  bytes per RAM word; data width = WSIZE*8
// ADDR_W        9  AXI byte-address width; word index = addr[8:2]
// PDK_FULLWORD  1  1: partial wstrb -> RMW with ram_we all-ones; 0: ram_we = wstrb directly
// PORTS
// axi_clk      in   1         single clock, also drives RAM128 CLK
// axi_reset_n  in   1         synchronous, active-low reset
// awvalid/awready  in/out  1   write-address handshake
// awaddr       in   ADDR_W    write byte address
// wvalid/wready    in/out  1   write-data handshake
// wdata        in   WSIZE*8   write data
// wstrb        in   WSIZE     byte strobes
// bvalid/bready    out/in  1   write-response handshake
// bresp        out  2         always 2'b00 (OKAY)
// arvalid/arready  in/out  1   read-address handshake
// araddr       in   ADDR_W    read byte address
// rvalid/rready    out/in  1   read-data handshake
// rdata        out  WSIZE*8   read data
// rresp        out  2         always 2'b00 (OKAY)
// ram_en       out  1         to RAM128 EN0
// ram_we       out  WSIZE     to RAM128 WE0
// ram_a        out  7         to RAM128 A0
// ram_di       out  WSIZE*8   to RAM128 Di0
// ram_do       in   WSIZE*8   from RAM128 Do0; valid the cycle after a read-enable cycle
// BEHAVIOUR
// - Reset: all outputs are 0. FSM goes to IDLE. Priority pointer is set to READ.
// - ready outputs are combinational from state: asserted only in IDLE. ram_* are registered.
// - Write acceptance: awready and wready assert together only when awvalid and wvalid are both 1 and the write wins arbitration.
// - Write acceptance: AW and W are never accepted separately.
// - Arbitration in IDLE when write and read are both pending: grant the side not granted last, then toggle the pointer.
// - With only one side pending, grant that side and do not toggle.
// - Address: word index = addr[8:2]. addr[1:0] are ignored and wrap is not possible.
// - Cycle numbering: the handshake happens in cycle 0.
// - FSM states: IDLE, RD, RD_CAP, RD_RESP, RMW_RD, RMW_MRG, WR, WR_RESP.
// - Read path IDLE->RD->RD_CAP->RD_RESP.
//   - RD (cycle 1): ram_en=1, ram_we=0.
//   - RD_CAP (cycle 2): rdata <= ram_do.
//   - RD_RESP (cycle 3+): rvalid=1, rdata held stable until rready; then back to IDLE.
// - Write, full strobe (or PDK_FULLWORD=0): IDLE->WR->WR_RESP.
//   - WR (cycle 1): ram_en=1, ram_we=wstrb (all-ones for a full strobe), ram_di=wdata.
//   - WR_RESP (cycle 2+): bvalid=1 until bready.
// - Write, partial strobe with PDK_FULLWORD=1: IDLE->RMW_RD->RMW_MRG->WR->WR_RESP.
//   - RMW_RD (cycle 1): read the word.
//   - RMW_MRG (cycle 2): merged = strobed bytes from wdata, other bytes from ram_do.
//   - WR (cycle 3): ram_we all-ones, ram_di=merged.
//   - bvalid asserts in cycle 4.
// - wstrb==0: no RAM access; go IDLE->WR_RESP and assert bvalid in cycle 1.
// - ram_en=0 and ram_we=0 in every state other than RD, RMW_RD and WR.
// - One outstanding transaction only. No new handshake is accepted until the response completes.
// - Reset mid-operation: the FSM returns to IDLE, any pending response is dropped, and a write not yet in WR is not performed.
// - The bridge gives no read-during-write hazard, because the port is used serially.
// TESTING
// - Write 0xDEADBEEF, strb 4'hF, to 0x000, then read 0x000:
//   - bvalid in cycle 2.
//   - rvalid in cycle 3 with rdata=0xDEADBEEF.
// - Preload 0x11223344 at 0x1FC, then write 0xAABBCCDD with strb 4'b0101 (PDK_FULLWORD=1):
//   - RMW_RD visible in cycle 1.
//   - ram_di=0x11BB33DD with ram_we=4'hF in cycle 3.
//   - Readback gives 0x11BB33DD.
// - awvalid+wvalid and arvalid all held high from reset for 4 transactions:
//   - grants alternate R,W,R,W.
//   - awready/wready are never high in the same cycle as arready.
// - Hold rready=0 for 5 cycles after rvalid:
//   - rdata stays stable.
//   - arready stays 0.
//   - the RAM sees no ram_en.
// - awvalid=1 with wvalid=0 for 3 cycles, then wvalid=1: awready stays 0 until both are valid, then both ready pulse together.
// - Assert axi_reset_n=0 in RMW_MRG, then release: no WR cycle occurs, the word is unchanged, and bvalid=0.
// - Write with strb=0: no ram_en, bvalid in cycle 1, data unchanged.

Source files
------------

// File: rtl/ram128_axil_ctrl.sv
// AXI4-Lite slave owning the single port of one RAM128 macro.
// Serialises AXI-Lite reads/writes into RAM EN0/WE0/A0/Di0 cycles; partial
// writes become read-modify-write when the macro only accepts full words.
module ram128_axil_ctrl #(
  parameter int WSIZE        = 4,
  parameter int ADDR_W       = 9,
  parameter int PDK_FULLWORD = 1
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [WSIZE*8-1:0]   wdata,
  input  logic [WSIZE-1:0]     wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_W-1:0]    araddr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [WSIZE*8-1:0]   rdata,
  output logic [1:0]           rresp,
  output logic                 ram_en,
  output logic [WSIZE-1:0]     ram_we,
  output logic [6:0]           ram_a,
  output logic [WSIZE*8-1:0]   ram_di,
  input  logic [WSIZE*8-1:0]   ram_do
);

  localparam int DW = WSIZE * 8;

  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, RD_RESP, RMW_RD, RMW_MRG, WR, WR_RESP
  } state_t;

  typedef enum logic {PRIO_RD, PRIO_WR} prio_t;

  state_t           state_q, state_d;
  prio_t            prio_q, prio_d;
  logic             ram_en_q, ram_en_d;
  logic [WSIZE-1:0] ram_we_q, ram_we_d;
  logic [6:0]       ram_a_q, ram_a_d;
  logic [DW-1:0]    ram_di_q, ram_di_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [WSIZE-1:0] wstrb_q, wstrb_d;

  logic             wr_pend, rd_pend, grant_wr, grant_rd;
  logic [DW-1:0]    merged;
  logic             unused_addr_bits;

  // Byte offset bits never select anything; the RAM is word addressed.
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Arbitration: ready only in IDLE (and out of reset); contested requests
  // go to the side named by the priority pointer, AW and W only together.
  assign wr_pend  = awvalid && wvalid;
  assign rd_pend  = arvalid;
  assign grant_wr = axi_reset_n && (state_q == IDLE) && wr_pend &&
                    (!rd_pend || (prio_q == PRIO_WR));
  assign grant_rd = axi_reset_n && (state_q == IDLE) && rd_pend &&
                    (!wr_pend || (prio_q == PRIO_RD));

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;
  assign bvalid  = (state_q == WR_RESP);
  assign rvalid  = (state_q == RD_RESP);
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;
  assign rdata   = rdata_q;
  assign ram_en  = ram_en_q;
  assign ram_we  = ram_we_q;
  assign ram_a   = ram_a_q;
  assign ram_di  = ram_di_q;

  // Merge held write bytes over the word just read back from the RAM.
  always_comb begin
    merged = ram_do;
    for (int unsigned i = 0; i < WSIZE; i++) begin
      if (wstrb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  // Next-state logic; RAM controls are computed for the state being entered
  // so that the registered ram_* line up with RD, RMW_RD and WR.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    ram_en_d = 1'b0;
    ram_we_d = '0;
    ram_a_d  = ram_a_q;
    ram_di_d = ram_di_q;
    rdata_d  = rdata_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (wr_pend && rd_pend) begin
          prio_d = (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
        end
        if (grant_rd) begin
          state_d  = RD;
          ram_en_d = 1'b1;
          ram_a_d  = araddr[8:2];
        end else if (grant_wr) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          ram_a_d = awaddr[8:2];
          if (wstrb == '0) begin
            state_d = WR_RESP;
          end else if ((PDK_FULLWORD != 0) && (wstrb != '1)) begin
            state_d  = RMW_RD;
            ram_en_d = 1'b1;
          end else begin
            state_d  = WR;
            ram_en_d = 1'b1;
            ram_we_d = wstrb;
            ram_di_d = wdata;
          end
        end
      end
      RD:      state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = ram_do;
        state_d = RD_RESP;
      end
      RD_RESP: if (rready) state_d = IDLE;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: begin
        state_d  = WR;
        ram_en_d = 1'b1;
        ram_we_d = '1;
        ram_di_d = merged;
      end
      WR:      state_d = WR_RESP;
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_RD;
      ram_en_q <= 1'b0;
      ram_we_q <= '0;
      ram_a_q  <= '0;
      ram_di_q <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_di_q <= ram_di_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_ram128_axil_ctrl.sv
// Self-checking bench for ram128_axil_ctrl: behavioural RAM128, word-array
// reference model, directed vector table, corner sequences, random traffic.
module tb_ram128_axil_ctrl;

  logic        clk = 1'b0;
  logic        axi_reset_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [8:0]  awaddr, araddr;
  logic [31:0] wdata, rdata, ram_di, ram_do;
  logic [3:0]  wstrb, ram_we;
  logic [1:0]  bresp, rresp;
  logic        ram_en;
  logic [6:0]  ram_a;

  always #5 clk = ~clk;

  ram128_axil_ctrl #(.WSIZE(4), .ADDR_W(9), .PDK_FULLWORD(1)) dut (
    .axi_clk(clk), .axi_reset_n(axi_reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Behavioural RAM128: byte-enabled write, registered read data.
  logic [31:0] mem [0:127];
  int          en_count = 0;
  always @(posedge clk) begin
    if (ram_en) begin
      mem[ram_a] <= (mem[ram_a] & ~bytemask(ram_we)) | (ram_di & bytemask(ram_we));
      ram_do     <= mem[ram_a];
      en_count   <= en_count + 1;
    end
  end

  // Reference model: word array indexed by byte address / 4.
  logic [31:0] ref_mem [0:127];
  int checks = 0;
  int failures = 0;

  task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = int'(a) / 4;
    ref_mem[w] = (ref_mem[w] & ~bytemask(s)) | (d & bytemask(s));
  endtask

  function automatic int exp_blat(input logic [3:0] s);
    if (s == 4'h0) return 1;
    if (s == 4'hF) return 2;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  logic        cyc_en [0:15];
  logic [3:0]  cyc_we [0:15];
  logic [6:0]  cyc_a  [0:15];
  logic [31:0] cyc_di [0:15];

  task automatic record(input int k);
    if (k < 16) begin
      cyc_en[k] = ram_en; cyc_we[k] = ram_we; cyc_a[k] = ram_a; cyc_di[k] = ram_di;
    end
  endtask

  task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int blat);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1; n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      timeout("write_addr_handshake");
      awvalid = 1'b0; wvalid = 1'b0; blat = -1;
      return;
    end
    record(0);
    blat = 0;
    do begin
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1; blat++; record(blat);
    end while (!bvalid && blat < 50);
  endtask

  task automatic axi_read(input logic [8:0] a, output logic [31:0] d, output int rlat);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      timeout("read_addr_handshake");
      arvalid = 1'b0; rlat = -1; d = '0;
      return;
    end
    rlat = 0;
    do begin
      @(negedge clk); arvalid = 1'b0; #1; rlat++;
    end while (!rvalid && rlat < 50);
    d = rdata;
  endtask

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [$];
  int          lat, n, ng, e0;
  logic [31:0] d, d0;
  bit          bad, bad2, bad3;
  logic [7:0]  grants [0:3];
  logic [7:0]  exp_g  [0:3];

  initial begin
    axi_reset_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    exp_g[0] = "R"; exp_g[1] = "W"; exp_g[2] = "R"; exp_g[3] = "W";

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid, ram_en, ram_we, ram_a, bresp, rresp}, '0);
    chk("reset_ram_di", ram_di, '0);
    chk("reset_rdata", rdata, '0);
    @(negedge clk); axi_reset_n = 1'b1;

    // Fill every word so later partial writes merge known data
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      axi_write(9'(w * 4), d, 4'hF, lat);
      model_write(9'(w * 4), d, 4'hF);
      chk("fill_blat", lat, 2);
    end

    // Directed vector table
    tbl.push_back('{1'b1, 9'h000, 32'hDEADBEEF, 4'hF, 32'h0,        2});
    tbl.push_back('{1'b0, 9'h000, 32'h0,        4'h0, 32'hDEADBEEF, 3});
    tbl.push_back('{1'b1, 9'h1FC, 32'h11223344, 4'hF, 32'h0,        2});
    tbl.push_back('{1'b1, 9'h1FC, 32'hAABBCCDD, 4'h5, 32'h0,        4});
    tbl.push_back('{1'b0, 9'h1FC, 32'h0,        4'h0, 32'h11BB33DD, 3});
    tbl.push_back('{1'b1, 9'h1FE, 32'h00000000, 4'h0, 32'h0,        1});
    tbl.push_back('{1'b0, 9'h1FD, 32'h0,        4'h0, 32'h11BB33DD, 3});
    tbl.push_back('{1'b1, 9'h004, 32'hCAFEF00D, 4'hF, 32'h0,        2});
    tbl.push_back('{1'b1, 9'h004, 32'h12345678, 4'h8, 32'h0,        4});
    tbl.push_back('{1'b0, 9'h006, 32'h0,        4'h0, 32'h12FEF00D, 3});
    tbl.push_back('{1'b1, 9'h007, 32'h00000099, 4'h1, 32'h0,        4});
    tbl.push_back('{1'b0, 9'h004, 32'h0,        4'h0, 32'h12FEF099, 3});
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, lat);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        chk($sformatf("tbl%0d_blat", i), lat, tbl[i].exp_lat);
      end else begin
        axi_read(tbl[i].addr, d, lat);
        chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
        chk($sformatf("tbl%0d_rlat", i), lat, tbl[i].exp_lat);
      end
    end

    // Read-modify-write RAM cycle detail
    axi_write(9'h1FC, 32'h11223344, 4'hF, lat);
    model_write(9'h1FC, 32'h11223344, 4'hF);
    axi_write(9'h1FC, 32'hAABBCCDD, 4'b0101, lat);
    model_write(9'h1FC, 32'hAABBCCDD, 4'b0101);
    chk("rmw_c1_en_we_a", {cyc_en[1], cyc_we[1], cyc_a[1]}, {1'b1, 4'h0, 7'h7F});
    chk("rmw_c2_en", cyc_en[2], 1'b0);
    chk("rmw_c3_en_we", {cyc_en[3], cyc_we[3]}, {1'b1, 4'hF});
    chk("rmw_c3_di", cyc_di[3], 32'h11BB33DD);
    chk("rmw_blat", lat, 4);
    axi_read(9'h1FC, d, lat);
    chk("rmw_readback", d, 32'h11BB33DD);

    // Zero-strobe write: no RAM access
    e0 = en_count;
    axi_write(9'h0C0, 32'h0BADF00D, 4'h0, lat);
    chk("strb0_blat", lat, 1);
    chk("strb0_no_ram_en", en_count, e0);
    axi_read(9'h0C0, d, lat);
    chk("strb0_data_unchanged", d, ref_mem[48]);

    // AW presented without W: nothing accepted until both are valid
    @(negedge clk);
    awaddr = 9'h040; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1; if (awready || wready) bad = 1;
      @(negedge clk);
    end
    chk("aw_only_no_ready", bad, 1'b0);
    wvalid = 1'b1; #1;
    chk("aw_w_ready_together", {awready, wready}, 2'b11);
    lat = 0;
    do begin @(negedge clk); awvalid = 0; wvalid = 0; #1; lat++; end while (!bvalid && lat < 50);
    model_write(9'h040, 32'h01020304, 4'hF);
    chk("aw_w_blat", lat, 2);

    // rready held low: rdata stable, no new grant, RAM idle
    @(negedge clk);
    araddr = 9'h1FC; arvalid = 1'b1; rready = 1'b0;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("rhold_handshake");
    lat = 0;
    do begin @(negedge clk); #1; lat++; end while (!rvalid && lat < 50);
    chk("rhold_rlat", lat, 3);
    d0 = rdata; e0 = en_count;
    chk("rhold_rdata", d0, ref_mem[127]);
    bad = 0; bad2 = 0; bad3 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (!rvalid) bad = 1;
      if (rdata !== d0) bad2 = 1;
      if (arready) bad3 = 1;
    end
    chk("rhold_rvalid_held", bad, 1'b0);
    chk("rhold_rdata_stable", bad2, 1'b0);
    chk("rhold_arready_low", bad3, 1'b0);
    chk("rhold_no_ram_en", en_count, e0);
    @(negedge clk); rready = 1'b1; arvalid = 1'b0;

    // Reset in RMW_MRG: write abandoned
    @(negedge clk);
    awaddr = 9'h080; wdata = 32'hFFFFFFFF; wstrb = 4'b0011; awvalid = 1; wvalid = 1; bready = 1;
    #1; n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) timeout("rstmid_handshake");
    @(negedge clk); awvalid = 0; wvalid = 0; #1;
    chk("rstmid_c1_rmw_rd", {ram_en, ram_we}, {1'b1, 4'h0});
    @(negedge clk); axi_reset_n = 1'b0; #1;
    chk("rstmid_c2_idle_ram", ram_en, 1'b0);
    e0 = en_count;
    @(negedge clk); axi_reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      #1; if (bvalid) bad = 1;
      @(negedge clk);
    end
    chk("rstmid_no_bvalid", bad, 1'b0);
    chk("rstmid_no_wr_cycle", en_count, e0);
    axi_read(9'h080, d, lat);
    chk("rstmid_word_unchanged", d, ref_mem[32]);

    // Contested traffic from reset: grants alternate starting with read
    @(negedge clk);
    axi_reset_n = 1'b0;
    awaddr = 9'h010; wdata = 32'h5A5A0001; wstrb = 4'hF; araddr = 9'h020;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk); #1;
    chk("reset_ready_gated", {awready, wready, arready}, 3'b000);
    @(negedge clk); axi_reset_n = 1'b1;
    ng = 0; bad = 0; bad2 = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if ((awready || wready) && arready) bad = 1;
      if (awready != wready) bad2 = 1;
      if (arready) begin grants[ng] = "R"; ng++; end
      else if (awready && wready) begin grants[ng] = "W"; ng++; end
      if (ng < 4) @(negedge clk);
    end
    @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (6) @(negedge clk);
    model_write(9'h010, 32'h5A5A0001, 4'hF);
    chk("arb_grant_count", ng, 4);
    chk("arb_no_overlap", bad, 1'b0);
    chk("arb_aw_w_together", bad2, 1'b0);
    for (int i = 0; i < 4 && i < ng; i++) chk($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
    axi_read(9'h010, d, lat);
    chk("arb_write_landed", d, 32'h5A5A0001);

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [8:0] a;
      logic [3:0] s;
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0) begin
        axi_read(a, d, lat);
        chk("rand_rdata", d, ref_mem[int'(a) / 4]);
        chk("rand_rlat", lat, 3);
      end else begin
        case ($urandom_range(0, 3))
          0:       s = 4'h0;
          1:       s = 4'hF;
          default: s = 4'($urandom);
        endcase
        d = $urandom;
        axi_write(a, d, s, lat);
        model_write(a, d, s);
        chk("rand_blat", lat, 64'(exp_blat(s)));
      end
    end
    for (int w = 0; w < 128; w += 9) begin
      axi_read(9'(w * 4), d, lat);
      chk("final_sweep", d, ref_mem[w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
